mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 197 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete as no-ops.
module mdu_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef MDU_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_res_q, neg_res_d;
  logic        skip_q, skip_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

  // Odd function codes (MULTU/DIVU) are the unsigned variants.
  assign signed_op = ~func[0];
  assign rs_neg    = signed_op & rs_val[31];
  assign rt_neg    = signed_op & rt_val[31];
  assign rs_mag    = rs_neg ? (32'd0 - rs_val) : rs_val;
  assign rt_mag    = rt_neg ? (32'd0 - rt_val) : rt_val;

  // acc holds {partial product, remaining multiplier bits}; shifted right each step.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;

`ifdef MDU_DIV_EN
  logic        is_div_q, is_div_d;
  logic        neg_rem_q, neg_rem_d;
  logic [32:0] rem_sh, div_trial;
  logic [31:0] quo_fix, rem_fix;

  // acc holds {remainder, dividend/quotient}; a negative trial restores the remainder.
  assign rem_sh    = acc_q[63:31];
  assign div_trial = rem_sh - {1'b0, opnd_q};
  assign quo_fix   = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix   = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    skip_d    = skip_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (func)
            F_MTHI: hi_d = rs_val;
            F_MTLO: lo_d = rs_val;
            F_MULT, F_MULTU: begin
              state_d   = ST_MUL;
              cnt_d     = 5'd0;
              acc_d     = {32'd0, rt_mag};
              opnd_d    = rs_mag;
              neg_res_d = rs_neg ^ rt_neg;
              skip_d    = 1'b0;
`ifdef MDU_DIV_EN
              is_div_d  = 1'b0;
`endif
            end
            F_DIV, F_DIVU: begin
`ifdef MDU_DIV_EN
              if (rt_val == 32'd0) begin
                state_d = ST_FIX;
                skip_d  = 1'b1;
              end else begin
                state_d   = ST_DIV;
                cnt_d     = 5'd0;
                acc_d     = {32'd0, rs_mag};
                opnd_d    = rt_mag;
                neg_res_d = rs_neg ^ rt_neg;
                neg_rem_d = rs_neg;
                is_div_d  = 1'b1;
                skip_d    = 1'b0;
              end
`else
              state_d = ST_FIX;
              skip_d  = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        acc_d = {(div_trial[32] ? rem_sh[31:0] : div_trial[31:0]), acc_q[30:0], ~div_trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
`endif
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!skip_q) begin
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_res_q <= 1'b0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      skip_q    <= skip_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus random ops, results checked through an expected queue.
// Follows MDU_DIV_EN so the reference model matches the build being simulated.
module tb_mdu_seq;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [5:0]  func;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  mdu_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .func(func),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural meaning of each op in plain 64-bit arithmetic.
  task automatic model_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (f)
      F_MTHI: m_hi = rs;
      F_MTLO: m_lo = rs;
      F_MULT: begin
        p = sa * sb;
        {m_hi, m_lo} = p;
        exp_q.push_back(p);
      end
      F_MULTU: begin
        p = {32'd0, rs} * {32'd0, rt};
        {m_hi, m_lo} = p;
        exp_q.push_back(p);
      end
      F_DIV: begin
        if (DIV_EN && rt != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        exp_q.push_back({m_hi, m_lo});
      end
      F_DIVU: begin
        if (DIV_EN && rt != 32'd0) begin
          m_lo = rs / rt;
          m_hi = rs % rt;
        end
        exp_q.push_back({m_hi, m_lo});
      end
      default: ;
    endcase
  endtask

  function automatic int exp_busy(input logic [5:0] f, input logic [31:0] rt);
    case (f)
      F_MULT, F_MULTU: return 33;
      F_DIV, F_DIVU:   return (DIV_EN && rt != 32'd0) ? 33 : 1;
      default:         return 0;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending result.
  always @(negedge CLK) begin
    if (RST === 1'b0 && done === 1'b1) begin
      check("done_busy_low", 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, required no pending result", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input string tag);
    int n = 0;
    int eb;
    eb = exp_busy(f, rt);
    @(negedge CLK);
    start = 1'b1; func = f; rs_val = rs; rt_val = rt;
    @(posedge CLK);
    model_op(f, rs, rt);
    @(negedge CLK);
    start = 1'b0; func = 6'($urandom_range(0, 63)); rs_val = $urandom; rt_val = $urandom;
    while (busy && n < 60) begin
      n++;
      @(negedge CLK);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(eb));
    if (f == F_MTHI || f == F_MTLO) check({tag, "_mt_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  funcs [6];
    logic [5:0]  abort_f;
    logic [63:0] prev;
    int          n;
    funcs = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

    RST = 1'b1; start = 1'b0; func = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    run_op(F_MTHI, 32'h11, 32'd5, "mthi");
    run_op(F_MTLO, 32'h22, 32'd6, "mtlo");
    run_op(F_DIVU, 32'd100, 32'd0, "divu_by_zero");
    check("divu_by_zero_keep", {hi, lo}, {32'h11, 32'h22});

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    prev = {hi, lo};
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_const", {hi, lo}, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : prev);
    prev = {hi, lo};
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {hi, lo}, DIV_EN ? 64'h0000_0000_8000_0000 : prev);

    // Start with MTHI at E5 of a running MULT must be ignored.
    @(negedge CLK);
    start = 1'b1; func = F_MULT; rs_val = 32'd5; rt_val = 32'hFFFF_FFF7;
    @(posedge CLK);
    model_op(F_MULT, 32'd5, 32'hFFFF_FFF7);
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; func = F_MTHI; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    check("overlap_still_busy", 64'(busy), 64'd1);
    wait_idle("overlap");
    check("overlap_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD3);

    // Reset at E10 aborts the operation with no done and cleared HI/LO.
    abort_f = DIV_EN ? F_DIVU : F_MULTU;
    @(negedge CLK);
    start = 1'b1; func = abort_f; rs_val = 32'd50; rt_val = 32'd7;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("abort_no_write", {hi, lo}, 64'd0);
    run_op(F_DIVU, 32'd50, 32'd7, "divu_after_abort");
    check("divu_after_abort_const", {hi, lo}, DIV_EN ? {32'd1, 32'd7} : 64'd0);

    // Start held high: second op is accepted on the edge after the done cycle.
    @(negedge CLK);
    start = 1'b1; func = F_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge CLK);
    model_op(F_MULTU, 32'd2, 32'd3);
    @(negedge CLK);
    func = F_DIVU; rs_val = 32'd9; rt_val = 32'd4;
    n = 0;
    while (!done && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_first_latency", 64'(n), 64'd33);
    check("b2b_first_lo", 64'(lo), 64'd6);
    @(posedge CLK);
    model_op(F_DIVU, 32'd9, 32'd4);
    @(negedge CLK);
    start = 1'b0;
    check("b2b_second_accept", 64'(busy), 64'd1);
    wait_idle("b2b");
    check("b2b_second_hilo", {hi, lo}, DIV_EN ? {32'd1, 32'd2} : {32'd0, 32'd6});

    for (int i = 0; i < 40; i++) begin
      run_op(funcs[$urandom_range(0, 5)], pick_val(), pick_val(), "rand");
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
